// File: rtl/serial_tc_to_sm_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude decoder:
// default width, FSM state type and the counter-width helper.
package serial_tc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Number of bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_tc_to_sm_if.sv
// Handshake bundle of serial_tc_to_sm: word input channel and sign/magnitude
// result channel. 'slave' is the decoder view, 'master' the producer/consumer view.
interface serial_tc_to_sm_if
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] In;
    logic             in_valid;
    logic             in_ready;
    logic             Sign;
    logic [WIDTH-1:0] Mag;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  In,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output Sign,
        output Mag,
        output out_valid
    );

    modport master (
        output In,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  Sign,
        input  Mag,
        input  out_valid
    );
endinterface

// File: rtl/serial_tc_to_sm_bit_cell.sv
// One step of the copy-to-first-one-then-invert rule. For a positive word
// every bit passes through; for a negative word bits up to and including the
// first 1 are copied and every later bit is inverted.
module tc_bit_cell (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    // Combinational bit transform and tracking of whether a 1 has been seen.
    always_comb begin
        out_bit       = b;
        seen_one_next = seen_one | b;
        if (sign && seen_one) begin
            out_bit = ~b;
        end else begin
            out_bit = b;
        end
    end

endmodule

// File: rtl/serial_tc_to_sm.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// A word is accepted in IDLE, consumed LSB-first over WIDTH cycles in SHIFT,
// and held as Sign/Mag in DONE until the consumer takes it.
// Optional feature macro: SERIAL_TC_MIN_FLAG_EN adds output min_flag, high in
// DONE when the accepted word was the most negative value.
module serial_tc_to_sm
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    serial_tc_to_sm_if.slave bus
`ifdef SERIAL_TC_MIN_FLAG_EN
    ,
    output logic min_flag
`endif
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_WORD  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] sreg_q,      sreg_d;
    logic [WIDTH-1:0] mag_q,       mag_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             seen_q,      seen_d;
    logic             sign_q,      sign_d;
    logic             word_min_q,  word_min_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             min_flag_q,  min_flag_d;

    logic accept_s;
    logic cell_bit_s;
    logic cell_seen_s;

    assign accept_s = bus.in_valid & in_ready_q;

    tc_bit_cell u_bit_cell (
        .b             (sreg_q[0]),
        .sign          (sign_q),
        .seen_one      (seen_q),
        .out_bit       (cell_bit_s),
        .seen_one_next (cell_seen_s)
    );

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= WORD_ZERO;
            mag_q       <= WORD_ZERO;
            cnt_q       <= CNT_ZERO;
            seen_q      <= 1'b0;
            sign_q      <= 1'b0;
            word_min_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            min_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            sign_q      <= sign_d;
            word_min_q  <= word_min_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            min_flag_q  <= min_flag_d;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH shift cycles, wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output next values; handshake flags follow the next state
    // so they are registered and line up with the state register.
    always_comb begin
        sreg_d     = sreg_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        sign_d     = sign_q;
        word_min_d = word_min_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sreg_d     = bus.In;
                    sign_d     = bus.In[WIDTH-1];
                    cnt_d      = CNT_ZERO;
                    seen_d     = 1'b0;
                    word_min_d = (bus.In == MIN_WORD);
                end else begin
                    sreg_d     = sreg_q;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the first (LSB) bit ends at bit 0.
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                mag_d  = {cell_bit_s, mag_q[WIDTH-1:1]};
                seen_d = cell_seen_s;
                cnt_d  = cnt_q + CNT_ONE;
            end
            DONE: begin
                mag_d = mag_q;
            end
            default: begin
                mag_d = mag_q;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        min_flag_d  = (state_d == DONE) & word_min_q;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sign      = sign_q;
    assign bus.Mag       = mag_q;

`ifdef SERIAL_TC_MIN_FLAG_EN
    assign min_flag = min_flag_q;
`else
    logic unused_min_flag_s;
    assign unused_min_flag_s = min_flag_q;
`endif

endmodule

// File: tb/tb_serial_tc_to_sm.sv
module tb_serial_tc_to_sm;
    import serial_tc_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_tc_to_sm_if #(.WIDTH(W)) bus ();
`ifdef SERIAL_TC_MIN_FLAG_EN
    logic min_flag;
`endif

    serial_tc_to_sm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SERIAL_TC_MIN_FLAG_EN
        ,
        .min_flag (min_flag)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: interpret word as signed integer, return {sign, |value|}.
    function automatic logic [W:0] ref_sm(input logic [W-1:0] x);
        int v;
        int a;
        logic [W:0] r;
        v = int'(x);
        if (x[W-1]) v = v - (1 << W);
        a = (v < 0) ? -v : v;
        r[W] = (v < 0);
        r[W-1:0] = a[W-1:0];
        return r;
    endfunction

    // Transaction-level model: phase 0 idle, 1 busy decoding, 2 result pending.
    int ph = 0;
    int rem = 0;
    logic e_sign = 1'b0;
    logic [W-1:0] e_mag = '0;
    logic e_min = 1'b0;
    bit chk_rst = 1'b1;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_in_ready", 32'(bus.in_ready), 32'(ph == 0));
            check("mon_out_valid", 32'(bus.out_valid), 32'(ph == 2));
            if (ph == 2) begin
                check("mon_sign", 32'(bus.Sign), 32'(e_sign));
                check("mon_mag", 32'(bus.Mag), 32'(e_mag));
            end
            if (chk_rst) begin
                check("mon_rst_sign", 32'(bus.Sign), 32'd0);
                check("mon_rst_mag", 32'(bus.Mag), 32'd0);
                chk_rst = 1'b0;
            end
`ifdef SERIAL_TC_MIN_FLAG_EN
            check("mon_min_flag", 32'(min_flag), 32'((ph == 2) && e_min));
`endif
            // Predict the effect of the coming rising edge.
            if (!rst_n) begin
                ph = 0;
                chk_rst = 1'b1;
            end else if (ph == 0) begin
                if (bus.in_valid) begin
                    {e_sign, e_mag} = ref_sm(bus.In);
                    e_min = (bus.In[W-1] && bus.In[W-2:0] == '0);
                    rem = W;
                    ph = 1;
                end
            end else if (ph == 1) begin
                rem--;
                if (rem == 0) ph = 2;
            end else begin
                if (bus.out_ready) ph = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic exp_s, input logic [W-1:0] exp_m,
                        input logic exp_min);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        bus.In = x;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("lit_sign", 32'(bus.Sign), 32'(exp_s));
        check("lit_mag", 32'(bus.Mag), 32'(exp_m));
`ifdef SERIAL_TC_MIN_FLAG_EN
        check("lit_min_flag", 32'(min_flag), 32'(exp_min));
`else
        if (exp_min) begin end
`endif
        if (bus.out_ready) begin
            @(posedge clk); #1;
            check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
            check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [W:0] r;
        bus.In = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pin the reference model with hand-computed values.
        r = ref_sm(4'b1011); check("model_m5", 32'(r), 32'b1_0101);
        r = ref_sm(4'b1000); check("model_min", 32'(r), 32'b1_1000);
        r = ref_sm(4'b0111); check("model_p7", 32'(r), 32'b0_0111);

        // Directed words with literal expectations.
        send(4'b0101, 1'b0, 4'b0101, 1'b0);
        send(4'b1011, 1'b1, 4'b0101, 1'b0);
        send(4'b1111, 1'b1, 4'b0001, 1'b0);
        send(4'b1000, 1'b1, 4'b1000, 1'b1);
        send(4'b0000, 1'b0, 4'b0000, 1'b0);

        // Exhaustive sweep against the reference model.
        for (int i = 0; i < 16; i++) begin
            r = ref_sm(4'(i));
            send(4'(i), r[W], r[W-1:0], (i == 8));
        end

        // Backpressure: result must hold, extra input pulses ignored.
        bus.out_ready = 1'b0;
        send(4'b1010, 1'b1, 4'b0110, 1'b0);
        for (int c = 0; c < 3; c++) begin
            bus.In = 4'b0001;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sign", 32'(bus.Sign), 32'd1);
            check("bp_mag", 32'(bus.Mag), 32'b0110);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(bus.out_valid), 32'd0);

        // Reset during the second shift cycle aborts the word.
        bus.In = 4'b0110;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mag", 32'(bus.Mag), 32'd0);
        rst_n = 1'b1;
        send(4'b0011, 1'b0, 4'b0011, 1'b0);

        @(posedge clk); #1;
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
